// File: rtl/dsdmnist_romsched_if.sv
// Host/RAM/datapath signal bundle for the MNIST weight-RAM sequencer.
// The DUT takes the slave view; the host/datapath side takes the master view.
interface dsdmnist_romsched_if;
  logic       i_START;
  logic       i_HOST_WE;
  logic [1:0] i_HOST_CHUNK;
  logic       o_HOST_ACK;
  logic [9:0] o_PA_ADDR;
  logic       o_PA_WE;
  logic [9:0] o_PB_ADDR;
  logic       o_PB_WE;
  logic       o_ROW_VALID;
  logic [1:0] o_TAG_LAYER;
  logic [7:0] o_TAG_NEURON;
  logic [1:0] o_TAG_CHUNK;
  logic       o_TAG_LAST;
  logic       i_WB_VALID;
  logic       o_BUSY;
  logic       o_DONE;

  modport master (
    output i_START, i_HOST_WE, i_HOST_CHUNK, i_WB_VALID,
    input  o_HOST_ACK, o_PA_ADDR, o_PA_WE, o_PB_ADDR, o_PB_WE, o_ROW_VALID,
    input  o_TAG_LAYER, o_TAG_NEURON, o_TAG_CHUNK, o_TAG_LAST, o_BUSY, o_DONE
  );

  modport slave (
    input  i_START, i_HOST_WE, i_HOST_CHUNK, i_WB_VALID,
    output o_HOST_ACK, o_PA_ADDR, o_PA_WE, o_PB_ADDR, o_PB_WE, o_ROW_VALID,
    output o_TAG_LAYER, o_TAG_NEURON, o_TAG_CHUNK, o_TAG_LAST, o_BUSY, o_DONE
  );
endinterface

// File: rtl/dsdmnist_romsched.sv
// Weight-RAM sequencer/arbiter: host loads image rows in IDLE, then three layers stream one address pair per cycle.
// Addresses are registered; row tags follow the addresses by one cycle (RAM latency); no stalls, write-back waits on i_WB_VALID.
module dsdmnist_romsched #(
  parameter int unsigned L1_NEURONS = 256,
  parameter int unsigned L2_NEURONS = 128,
  parameter int unsigned L3_NEURONS = 10,
  parameter int unsigned L2_WBASE   = 768,
  parameter int unsigned L3_WBASE   = 896,
  parameter int unsigned L1_OUT     = 920,
  parameter int unsigned L2_OUT     = 921,
  parameter int unsigned IMG_BASE   = 960
) (
  input logic             i_CLK,
  input logic             i_RST_n,
  dsdmnist_romsched_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_L1, S_W1, S_L2, S_W2, S_L3, S_W3} state_e;

  localparam logic [7:0] L1_LAST = 8'(L1_NEURONS - 1);
  localparam logic [7:0] L2_LAST = 8'(L2_NEURONS - 1);
  localparam logic [7:0] L3_LAST = 8'(L3_NEURONS - 1);

  state_e     state_q, state_d;
  logic [7:0] n_q, n_d;
  logic [1:0] c_q, c_d;
  logic [9:0] pa_addr_q, pa_addr_d;
  logic [9:0] pb_addr_q, pb_addr_d;
  logic       pa_we_q, pa_we_d;
  logic       pb_we_q, pb_we_d;
  logic       ack_q, ack_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  // iss_* describe the pair currently on the address bus; row_* the RAM data one cycle later
  logic       iss_vld_q, iss_vld_d;
  logic [1:0] iss_layer_q, iss_layer_d;
  logic [7:0] iss_neuron_q, iss_neuron_d;
  logic [1:0] iss_chunk_q, iss_chunk_d;
  logic       iss_last_q, iss_last_d;
  logic       row_vld_q;
  logic [1:0] row_layer_q;
  logic [7:0] row_neuron_q;
  logic [1:0] row_chunk_q;
  logic       row_last_q;

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    c_d          = c_q;
    pa_addr_d    = pa_addr_q;
    pb_addr_d    = pb_addr_q;
    pa_we_d      = 1'b0;
    pb_we_d      = 1'b0;
    ack_d        = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    iss_vld_d    = 1'b0;
    iss_layer_d  = 2'd0;
    iss_neuron_d = 8'd0;
    iss_chunk_d  = 2'd0;
    iss_last_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A valid host write takes priority over a start in the same cycle
        if (bus.i_HOST_WE && bus.i_HOST_CHUNK != 2'd3) begin
          pa_addr_d = 10'(IMG_BASE) + 10'(bus.i_HOST_CHUNK);
          pa_we_d   = 1'b1;
          ack_d     = 1'b1;
        end else if (bus.i_START) begin
          state_d = S_L1;
          busy_d  = 1'b1;
          n_d     = 8'd0;
          c_d     = 2'd0;
        end
      end
      S_L1: begin
        pa_addr_d    = 10'(n_q) * 10'd3 + 10'(c_q);
        pb_addr_d    = 10'(IMG_BASE) + 10'(c_q);
        iss_vld_d    = 1'b1;
        iss_layer_d  = 2'd1;
        iss_neuron_d = n_q;
        iss_chunk_d  = c_q;
        iss_last_d   = (c_q == 2'd2);
        if (c_q == 2'd2) begin
          c_d = 2'd0;
          if (n_q == L1_LAST) begin
            n_d     = 8'd0;
            state_d = S_W1;
          end else begin
            n_d = n_q + 8'd1;
          end
        end else begin
          c_d = c_q + 2'd1;
        end
      end
      S_W1: begin
        if (bus.i_WB_VALID) begin
          pb_addr_d = 10'(L1_OUT);
          pb_we_d   = 1'b1;
          state_d   = S_L2;
        end
      end
      S_L2: begin
        pa_addr_d    = 10'(L2_WBASE) + 10'(n_q);
        pb_addr_d    = 10'(L1_OUT);
        iss_vld_d    = 1'b1;
        iss_layer_d  = 2'd2;
        iss_neuron_d = n_q;
        iss_last_d   = 1'b1;
        if (n_q == L2_LAST) begin
          n_d     = 8'd0;
          state_d = S_W2;
        end else begin
          n_d = n_q + 8'd1;
        end
      end
      S_W2: begin
        if (bus.i_WB_VALID) begin
          pb_addr_d = 10'(L2_OUT);
          pb_we_d   = 1'b1;
          state_d   = S_L3;
        end
      end
      S_L3: begin
        pa_addr_d    = 10'(L3_WBASE) + 10'(n_q);
        pb_addr_d    = 10'(L2_OUT);
        iss_vld_d    = 1'b1;
        iss_layer_d  = 2'd3;
        iss_neuron_d = n_q;
        iss_last_d   = 1'b1;
        if (n_q == L3_LAST) begin
          n_d     = 8'd0;
          state_d = S_W3;
        end else begin
          n_d = n_q + 8'd1;
        end
      end
      S_W3: begin
        if (bus.i_WB_VALID) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q      <= S_IDLE;
      n_q          <= 8'd0;
      c_q          <= 2'd0;
      pa_addr_q    <= 10'd0;
      pb_addr_q    <= 10'd0;
      pa_we_q      <= 1'b0;
      pb_we_q      <= 1'b0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      iss_vld_q    <= 1'b0;
      iss_layer_q  <= 2'd0;
      iss_neuron_q <= 8'd0;
      iss_chunk_q  <= 2'd0;
      iss_last_q   <= 1'b0;
      row_vld_q    <= 1'b0;
      row_layer_q  <= 2'd0;
      row_neuron_q <= 8'd0;
      row_chunk_q  <= 2'd0;
      row_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      c_q          <= c_d;
      pa_addr_q    <= pa_addr_d;
      pb_addr_q    <= pb_addr_d;
      pa_we_q      <= pa_we_d;
      pb_we_q      <= pb_we_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      iss_vld_q    <= iss_vld_d;
      iss_layer_q  <= iss_layer_d;
      iss_neuron_q <= iss_neuron_d;
      iss_chunk_q  <= iss_chunk_d;
      iss_last_q   <= iss_last_d;
      row_vld_q    <= iss_vld_q;
      row_layer_q  <= iss_layer_q;
      row_neuron_q <= iss_neuron_q;
      row_chunk_q  <= iss_chunk_q;
      row_last_q   <= iss_last_q;
    end
  end

  assign bus.o_HOST_ACK   = ack_q;
  assign bus.o_PA_ADDR    = pa_addr_q;
  assign bus.o_PA_WE      = pa_we_q;
  assign bus.o_PB_ADDR    = pb_addr_q;
  assign bus.o_PB_WE      = pb_we_q;
  assign bus.o_ROW_VALID  = row_vld_q;
  assign bus.o_TAG_LAYER  = row_layer_q;
  assign bus.o_TAG_NEURON = row_neuron_q;
  assign bus.o_TAG_CHUNK  = row_chunk_q;
  assign bus.o_TAG_LAST   = row_last_q;
  assign bus.o_BUSY       = busy_q;
  assign bus.o_DONE       = done_q;

endmodule

// File: tb/tb_dsdmnist_romsched.sv
// Bench for dsdmnist_romsched: directed sequence with randomized timing, rows checked against a layer-walk model.
// Each logged row pairs its tags with the address pair seen on the previous cycle.
module tb_dsdmnist_romsched;

  typedef struct packed {
    logic [1:0] layer;
    logic [7:0] neuron;
    logic [1:0] chunk;
    logic       last;
    logic [9:0] pa;
    logic [9:0] pb;
  } row_t;

  logic i_CLK = 1'b0;
  logic i_RST_n = 1'b0;
  dsdmnist_romsched_if bus();

  dsdmnist_romsched dut (.i_CLK(i_CLK), .i_RST_n(i_RST_n), .bus(bus));

  always #5 i_CLK = ~i_CLK;

  int n_chk = 0;
  int n_fail = 0;

  row_t       rows[$];
  row_t       exp_rows[$];
  logic [9:0] pa_wr[$];
  logic [9:0] pb_wr[$];
  int         ack_cnt = 0;
  int         done_cnt = 0;
  int         collide = 0;
  logic [9:0] prev_pa = 10'd0;
  logic [9:0] prev_pb = 10'd0;

  always @(negedge i_CLK) begin
    if (bus.o_ROW_VALID)
      rows.push_back('{bus.o_TAG_LAYER, bus.o_TAG_NEURON, bus.o_TAG_CHUNK, bus.o_TAG_LAST, prev_pa, prev_pb});
    if (bus.o_PA_WE) pa_wr.push_back(bus.o_PA_ADDR);
    if (bus.o_PB_WE) pb_wr.push_back(bus.o_PB_ADDR);
    if (bus.o_PA_WE && bus.o_PB_WE) collide++;
    if (bus.o_HOST_ACK) ack_cnt++;
    if (bus.o_DONE) done_cnt++;
    prev_pa = bus.o_PA_ADDR;
    prev_pb = bus.o_PB_ADDR;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {bus.o_HOST_ACK, bus.o_PA_ADDR, bus.o_PA_WE, bus.o_PB_ADDR, bus.o_PB_WE,
              bus.o_ROW_VALID, bus.o_TAG_LAYER, bus.o_TAG_NEURON, bus.o_TAG_CHUNK,
              bus.o_TAG_LAST, bus.o_BUSY, bus.o_DONE}, 64'd0);
  endtask

  task automatic clear_logs();
    rows.delete();
    pa_wr.delete();
    pb_wr.delete();
    ack_cnt = 0;
    done_cnt = 0;
    collide = 0;
  endtask

  task automatic wait_rows(input int n, input string tag);
    int k = 0;
    while (rows.size() < n && k < 3000) begin
      @(negedge i_CLK);
      k++;
    end
    chk(tag, 64'(rows.size() >= n), 64'd1);
  endtask

  task automatic pulse(input bit wb, input bit start, input bit hwe, input logic [1:0] chunk);
    @(posedge i_CLK);
    #1;
    bus.i_WB_VALID   = wb;
    bus.i_START      = start;
    bus.i_HOST_WE    = hwe;
    bus.i_HOST_CHUNK = chunk;
    @(posedge i_CLK);
    #1;
    bus.i_WB_VALID = 1'b0;
    bus.i_START    = 1'b0;
    bus.i_HOST_WE  = 1'b0;
    bus.i_HOST_CHUNK = 2'd0;
  endtask

  task automatic host_write(input logic [1:0] chunk);
    logic ok;
    ok = (chunk != 2'd3);
    pulse(1'b0, 1'b0, 1'b1, chunk);
    @(negedge i_CLK);
    chk($sformatf("host_ack_c%0d", chunk), 64'(bus.o_HOST_ACK), 64'(ok));
    chk($sformatf("host_we_c%0d", chunk), 64'(bus.o_PA_WE), 64'(ok));
    if (ok) chk($sformatf("host_addr_c%0d", chunk), 64'(bus.o_PA_ADDR), 64'(960 + chunk));
    @(negedge i_CLK);
    chk("host_ack_one_cycle", 64'({bus.o_HOST_ACK, bus.o_PA_WE}), 64'd0);
  endtask

  task automatic wb_after_delay();
    repeat ($urandom_range(1, 6)) @(posedge i_CLK);
    pulse(1'b1, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic run_inference(input bit interfere, input string nm);
    int k;
    clear_logs();
    pulse(1'b0, 1'b1, 1'b0, 2'd0);
    @(negedge i_CLK);
    chk({nm, "_busy_after_start"}, 64'(bus.o_BUSY), 64'd1);
    if (interfere) begin
      wait_rows(100, {nm, "_wait_l1_mid"});
      pulse(1'b1, 1'b0, 1'b0, 2'd0);
    end
    wait_rows(768, {nm, "_wait_l1_end"});
    wb_after_delay();
    wait_rows(768 + 20, {nm, "_wait_l2_mid"});
    if (interfere) pulse(1'b0, 1'b1, 1'b1, 2'd1);
    wait_rows(896, {nm, "_wait_l2_end"});
    wb_after_delay();
    wait_rows(906, {nm, "_wait_l3_end"});
    wb_after_delay();
    k = 0;
    while (done_cnt == 0 && k < 50) begin
      @(negedge i_CLK);
      k++;
    end
    chk({nm, "_done_seen"}, 64'(done_cnt), 64'd1);
    @(negedge i_CLK);
    chk({nm, "_idle_after_done"}, 64'({bus.o_BUSY, bus.o_DONE}), 64'd0);
    chk({nm, "_row_count"}, 64'(rows.size()), 64'(exp_rows.size()));
    for (int i = 0; i < rows.size() && i < exp_rows.size(); i++)
      chk($sformatf("%s_row%0d", nm, i), 64'(rows[i]), 64'(exp_rows[i]));
    chk({nm, "_pb_writes"}, 64'(pb_wr.size()), 64'd2);
    if (pb_wr.size() == 2) begin
      chk({nm, "_pb_wr0"}, 64'(pb_wr[0]), 64'd920);
      chk({nm, "_pb_wr1"}, 64'(pb_wr[1]), 64'd921);
    end
    chk({nm, "_no_pa_writes_busy"}, 64'(pa_wr.size()), 64'd0);
    chk({nm, "_no_ack_busy"}, 64'(ack_cnt), 64'd0);
    chk({nm, "_no_collide"}, 64'(collide), 64'd0);
  endtask

  initial begin
    logic [1:0] ch;
    bus.i_START = 1'b0;
    bus.i_HOST_WE = 1'b0;
    bus.i_HOST_CHUNK = 2'd0;
    bus.i_WB_VALID = 1'b0;

    // Reference walk: layer 1 neuron-major/chunk-minor, then layers 2 and 3 one row per neuron
    for (int n = 0; n < 256; n++)
      for (int c = 0; c < 3; c++)
        exp_rows.push_back('{2'd1, 8'(n), 2'(c), c == 2, 10'(3 * n + c), 10'(960 + c)});
    for (int n = 0; n < 128; n++)
      exp_rows.push_back('{2'd2, 8'(n), 2'd0, 1'b1, 10'(768 + n), 10'd920});
    for (int n = 0; n < 10; n++)
      exp_rows.push_back('{2'd3, 8'(n), 2'd0, 1'b1, 10'(896 + n), 10'd921});

    repeat (3) @(negedge i_CLK);
    chk_zero("reset_outputs");
    i_RST_n = 1'b1;
    @(negedge i_CLK);
    chk_zero("post_reset_idle");

    host_write(2'd0);
    host_write(2'd1);
    host_write(2'd2);
    host_write(2'd3);
    repeat (3) begin
      ch = 2'($urandom_range(0, 3));
      host_write(ch);
    end

    run_inference(1'b0, "run1");

    clear_logs();
    pulse(1'b0, 1'b1, 1'b1, 2'd1);
    @(negedge i_CLK);
    chk("simul_ack", 64'({bus.o_HOST_ACK, bus.o_PA_WE}), 64'd3);
    chk("simul_addr", 64'(bus.o_PA_ADDR), 64'd961);
    chk("simul_not_busy", 64'(bus.o_BUSY), 64'd0);
    repeat (4) @(negedge i_CLK);
    chk("simul_still_idle", 64'({bus.o_BUSY, bus.o_ROW_VALID}), 64'd0);

    run_inference(1'b1, "run2");

    clear_logs();
    pulse(1'b0, 1'b1, 1'b0, 2'd0);
    wait_rows(768, "rst_wait_l1_end");
    wb_after_delay();
    wait_rows(768 + 41, "rst_wait_n40");
    #2;
    i_RST_n = 1'b0;
    #1;
    chk_zero("midrun_reset_immediate");
    repeat (3) @(negedge i_CLK);
    chk_zero("midrun_reset_hold");
    chk("midrun_no_more_pb_writes", 64'(pb_wr.size()), 64'd1);
    i_RST_n = 1'b1;
    host_write(2'($urandom_range(0, 2)));
    run_inference(1'b0, "run3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
